instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Feeds the processor control unit. Fetches 16-bit instructions from a synchronous instruction ROM and
//  presents them on instr_out, which drives the control unit d_in. Holds run high until the control unit
//  reports done, then retires the instruction and advances the PC. Supports halt, single-step and a
//  done-timeout watchdog.
// PARAMETERS
//  ADDR_W        8    instruction memory address width; pc wraps modulo 2**ADDR_W
//  PROG_LEN      256  instruction count, 1..2**ADDR_W; halt after retiring address PROG_LEN-1
//  DONE_TIMEOUT  8    maximum ISSUE cycles without done before a timeout error (>=5)
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       level; sampled in IDLE/HALTED only, begins a run from pc=0
//  step_mode    in   1       1 = pause in STEP_WAIT after every retired instruction
//  step         in   1       1-cycle pulse; releases STEP_WAIT only
//  imem_rd_en   out  1       ROM read strobe; data is valid the following cycle
//  imem_addr    out  ADDR_W  ROM address (= pc)
//  imem_data    in   16      ROM read data
//  instr_out    out  16      instruction to the control unit d_in; stable throughout ISSUE
//  run          out  1       control unit run
//  done         in   1       control unit done (high in its final state)
//  pc           out  ADDR_W  program counter
//  instr_count  out  16      retired instructions since start; saturates at 16'hFFFF
//  busy         out  1       high in FETCH/LOAD/ISSUE/RETIRE/STEP_WAIT
//  halted       out  1       high in HALTED
//  timeout_err  out  1       high in ERROR; sticky until reset
// BEHAVIOUR
//  Reset (async): state=IDLE. pc, instr_count and instr_out are 0. run, imem_rd_en, busy, halted and
//   timeout_err are 0.
//  Every output decodes from registers; there is no combinational path from any input to any output.
//  IDLE: on start, clear pc and instr_count, then go to FETCH.
//  FETCH: 1 cycle. imem_rd_en=1, imem_addr=pc. Go to LOAD.
//  LOAD: 1 cycle. Capture imem_data into instr_out.
//   - If imem_data[1:0]==2'b11 (HALT_OP), go to HALTED. The instruction is not issued, and pc and
//     instr_count are unchanged.
//   - Otherwise go to ISSUE.
//  ISSUE: run=1 and the watchdog counts.
//   - done==1 -> RETIRE. The nominal stay is 4 cycles.
//   - The watchdog reaches DONE_TIMEOUT with done never seen -> ERROR, and run drops the same edge.
//  RETIRE: 1 cycle, run=0.
//   - pc <= pc+1 (wrapping); instr_count <= instr_count+1 (saturating).
//   - Next state: HALTED if the old pc == PROG_LEN-1 (compare at ADDR_W+1 bits); else STEP_WAIT if
//     step_mode; else FETCH.
//  STEP_WAIT: wait for step, then go to FETCH. Clearing step_mode here also resumes, to FETCH.
//  HALTED: on start, clear pc and instr_count, then go to FETCH.
//  ERROR: terminal until reset. start and step are ignored.
//  Throughput: 7 cycles per instruction (FETCH, LOAD, 4x ISSUE, RETIRE).
//  Ignored events:
//   - start while busy, and step outside STEP_WAIT.
//   - done outside ISSUE (no error raised).
//   - done and watchdog expiry in the same cycle: done wins, go to RETIRE.
//  Reset mid-operation: run drops asynchronously. The control unit shares reset and returns to its
//   STATE0 together with the sequencer.
// STRUCTURE
//  Shared package seq_pkg holds:
//   - state encodings (IDLE, FETCH, LOAD, ISSUE, RETIRE, STEP_WAIT, HALTED, ERROR; 3 bits)
//   - HALT_OP=2'b11, plus the instruction field positions RX[15:13], RY[12:10], ALU[4:2], MODE[1:0],
//     which the control unit also uses
//  One natural sub-module, seq_watchdog: a clearable counter with an expire flag, cleared on ISSUE
//   entry and counting while in ISSUE. Everything else is a single FSM plus PC/count registers.
// TESTING
//  1. ROM {16'h2404,16'h4808,16'h600C}, PROG_LEN=3, start at t0
//     -> three 4-cycle run bursts; pc=3, instr_count=3, halted=1 at t0+22.
//  2. ROM[1]=16'h0003 -> one run burst only; halted=1 with pc=1, instr_count=1; run never high for addr 1.
//  3. step_mode=1 -> STEP_WAIT after each RETIRE with run=0; a step during ISSUE has no effect;
//     a step in STEP_WAIT gives imem_rd_en the next cycle.
//  4. done tied low, DONE_TIMEOUT=8 -> run high exactly 8 cycles, then timeout_err=1;
//     a later start is ignored until reset.
//  5. reset asserted in the 2nd ISSUE cycle -> run=0 and busy=0 before the next edge; pc=0, instr_count=0.
//  6. From HALTED with pc=3: start -> pc=0, instr_count=0, fetch of addr 0 the next cycle.
//     Also a wrap check: ADDR_W=2, PROG_LEN=4 halts after pc=3, and pc reads 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared sequencer types: FSM state encoding and instruction field layout.
// The control unit decodes the same fields, so keep them in one place.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_RETIRE,
        S_STEP_WAIT,
        S_HALTED,
        S_ERROR
    } state_t;

    localparam logic [1:0] HALT_OP = 2'b11;

    localparam int RX_HI   = 15;
    localparam int RX_LO   = 13;
    localparam int RY_HI   = 12;
    localparam int RY_LO   = 10;
    localparam int ALU_HI  = 4;
    localparam int ALU_LO  = 2;
    localparam int MODE_HI = 1;
    localparam int MODE_LO = 0;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[MODE_HI:MODE_LO] == HALT_OP;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction ROM port plus control-unit handshake (instr/run/done).
// master = sequencer side, slave = ROM / control unit side.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
) ();

    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic [15:0]       instr_out;
    logic              run;
    logic              done;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_data,
        output instr_out,
        output run,
        input  done
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_data,
        input  instr_out,
        input  run,
        output done
    );

endinterface

// File: rtl/seq_watchdog.sv
// Done-timeout watchdog: cleared on ISSUE entry, counts while enabled.
// expire is high in the last allowed cycle so the FSM can leave on that edge.
module seq_watchdog #(
    parameter int DONE_TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(DONE_TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = cnt == W'(DONE_TIMEOUT - 1);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a sync ROM, issues to the control
// unit, retires on done, with halt, single-step and a done watchdog.
module instr_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int PROG_LEN     = 256,
    parameter int DONE_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    instr_sequencer_if.master    bus,
    output logic [ADDR_W-1:0]    pc,
    output logic [15:0]          instr_count,
    output logic                 busy,
    output logic                 halted,
    output logic                 timeout_err
);

    import seq_pkg::*;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       cnt_q;
    logic [15:0]       instr_q;
    logic              clr_run;
    logic              ld_ir;
    logic              retire;
    logic              wd_clr;
    logic              wd_expire;
    logic              last;

    // Compare one bit wider so PROG_LEN == 2**ADDR_W still matches.
    assign last = {1'b0, pc_q} == (ADDR_W + 1)'(PROG_LEN - 1);

    seq_watchdog #(
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (state == S_ISSUE),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clr_run  = 1'b0;
        ld_ir    = 1'b0;
        retire   = 1'b0;
        wd_clr   = 1'b0;
        unique case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_nx = S_FETCH;
                    clr_run  = 1'b1;
                end
            end
            S_FETCH: state_nx = S_LOAD;
            S_LOAD: begin
                ld_ir    = 1'b1;
                wd_clr   = 1'b1;
                state_nx = is_halt(bus.imem_data) ? S_HALTED : S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.done) begin
                    state_nx = S_RETIRE;
                end else if (wd_expire) begin
                    state_nx = S_ERROR;
                end
            end
            S_RETIRE: begin
                retire = 1'b1;
                if (last) begin
                    state_nx = S_HALTED;
                end else if (step_mode) begin
                    state_nx = S_STEP_WAIT;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_STEP_WAIT: begin
                if (step || !step_mode) begin
                    state_nx = S_FETCH;
                end
            end
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            if (clr_run) begin
                pc_q  <= '0;
                cnt_q <= '0;
            end else if (retire) begin
                pc_q <= pc_q + ADDR_W'(1);
                if (cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            if (ld_ir) begin
                instr_q <= bus.imem_data;
            end
        end
    end

    assign bus.imem_rd_en = state == S_FETCH;
    assign bus.imem_addr  = pc_q;
    assign bus.instr_out  = instr_q;
    assign bus.run        = state == S_ISSUE;

    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign busy        = state inside {S_FETCH, S_LOAD, S_ISSUE,
                                       S_RETIRE, S_STEP_WAIT};
    assign halted      = state == S_HALTED;
    assign timeout_err = state == S_ERROR;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ROM and control-unit models,
// hand-computed expectations checked through a single check task.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        done_en = 1'b1;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    logic        busy, halted, timeout_err;

    logic        start2 = 1'b0;
    logic [1:0]  pc2;
    logic [15:0] count2;
    logic        busy2, halted2, terr2;

    logic [15:0] rom [256];
    logic [15:0] rom2 [4];

    int n_chk = 0;
    int n_fail = 0;
    int bursts = 0;
    int run_cyc = 0;
    logic run_d = 1'b0;
    int cu_cnt, cu_cnt2;

    instr_sequencer_if #(.ADDR_W(8)) bus ();
    instr_sequencer_if #(.ADDR_W(2)) bus2 ();

    instr_sequencer #(
        .ADDR_W(8), .PROG_LEN(3), .DONE_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .step_mode(step_mode), .step(step), .bus(bus),
        .pc(pc), .instr_count(instr_count), .busy(busy),
        .halted(halted), .timeout_err(timeout_err)
    );

    instr_sequencer #(
        .ADDR_W(2), .PROG_LEN(4), .DONE_TIMEOUT(8)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .step_mode(1'b0), .step(1'b0), .bus(bus2),
        .pc(pc2), .instr_count(count2), .busy(busy2),
        .halted(halted2), .timeout_err(terr2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_data <= rom[bus.imem_addr];
        if (bus2.imem_rd_en) bus2.imem_data <= rom2[bus2.imem_addr];
    end

    // Control unit model: done in the 4th run cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cu_cnt  <= 0;
            cu_cnt2 <= 0;
        end else begin
            cu_cnt  <= bus.run ? cu_cnt + 1 : 0;
            cu_cnt2 <= bus2.run ? cu_cnt2 + 1 : 0;
        end
    end

    assign bus.done  = done_en && bus.run && cu_cnt == 3;
    assign bus2.done = bus2.run && cu_cnt2 == 3;

    always @(negedge clk) begin
        if (bus.run && !run_d) bursts++;
        if (bus.run) run_cyc++;
        run_d = bus.run;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int k = 0;
        while (k < 80 && !halted) begin
            @(negedge clk);
            k++;
        end
        check(tag, halted, 1);
    endtask

    initial begin
        int k, b0, r0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0003;
        rom[0] = 16'h2404;
        rom[1] = 16'h4808;
        rom[2] = 16'h600C;
        for (int i = 0; i < 4; i++) rom2[i] = 16'h0004;

        do_reset();
        check("rst_pc", pc, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_instr", bus.instr_out, 0);
        check("rst_run", bus.run, 0);
        check("rst_rd_en", bus.imem_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_terr", timeout_err, 0);

        // Straight program, three instructions.
        b0 = bursts;
        r0 = run_cyc;
        pulse_start();
        k = 1;
        while (k < 80 && !halted) begin
            @(negedge clk);
            k++;
        end
        check("t1_cycles", k, 22);
        check("t1_halted", halted, 1);
        check("t1_pc", pc, 3);
        check("t1_cnt", instr_count, 3);
        check("t1_bursts", bursts - b0, 3);
        check("t1_runcyc", run_cyc - r0, 12);
        check("t1_instr", bus.instr_out, 16'h600C);
        check("t1_busy", busy, 0);

        // HALT opcode at address 1.
        do_reset();
        rom[1] = 16'h0003;
        b0 = bursts;
        pulse_start();
        wait_halt("t2_wait");
        check("t2_pc", pc, 1);
        check("t2_cnt", instr_count, 1);
        check("t2_bursts", bursts - b0, 1);
        check("t2_instr", bus.instr_out, 16'h0003);
        rom[1] = 16'h4808;

        // Single-step.
        do_reset();
        step_mode = 1'b1;
        pulse_start();
        k = 0;
        while (k < 20 && !bus.run) begin
            @(negedge clk);
            k++;
        end
        check("t3_run_wait", bus.run, 1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        k = 0;
        while (k < 20 && bus.run) begin
            @(negedge clk);
            k++;
        end
        check("t3_retire_wait", bus.run, 0);
        repeat (4) @(negedge clk);
        check("t3_sw_run", bus.run, 0);
        check("t3_sw_rd_en", bus.imem_rd_en, 0);
        check("t3_sw_busy", busy, 1);
        check("t3_sw_pc", pc, 1);
        check("t3_sw_cnt", instr_count, 1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("t3_step_rd_en", bus.imem_rd_en, 1);
        check("t3_step_addr", bus.imem_addr, 1);
        k = 0;
        while (k < 20 && !bus.run) begin
            @(negedge clk);
            k++;
        end
        while (k < 40 && bus.run) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("t3_sw2_busy", busy, 1);
        check("t3_sw2_rd_en", bus.imem_rd_en, 0);
        step_mode = 1'b0;
        @(negedge clk);
        check("t3_resume_rd_en", bus.imem_rd_en, 1);
        check("t3_resume_addr", bus.imem_addr, 2);
        wait_halt("t3_wait");
        check("t3_cnt", instr_count, 3);

        // Watchdog timeout.
        do_reset();
        done_en = 1'b0;
        r0 = run_cyc;
        pulse_start();
        k = 0;
        while (k < 40 && !timeout_err) begin
            @(negedge clk);
            k++;
        end
        check("t4_terr", timeout_err, 1);
        check("t4_runcyc", run_cyc - r0, 8);
        check("t4_run", bus.run, 0);
        check("t4_busy", busy, 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_sticky", timeout_err, 1);
        check("t4_ign_busy", busy, 0);
        check("t4_ign_rd_en", bus.imem_rd_en, 0);
        check("t4_runcyc2", run_cyc - r0, 8);
        done_en = 1'b1;

        // Reset in the 2nd ISSUE cycle of instruction 2.
        do_reset();
        check("t5_rst_terr", timeout_err, 0);
        pulse_start();
        k = 0;
        while (k < 40 && !(bus.run && pc == 8'd1)) begin
            @(negedge clk);
            k++;
        end
        check("t5_issue2", bus.run && pc == 8'd1, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_run", bus.run, 0);
        check("t5_busy", busy, 0);
        check("t5_pc", pc, 0);
        check("t5_cnt", instr_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Restart from HALTED.
        pulse_start();
        wait_halt("t6_wait");
        check("t6_pc_halt", pc, 3);
        pulse_start();
        check("t6_pc", pc, 0);
        check("t6_cnt", instr_count, 0);
        check("t6_rd_en", bus.imem_rd_en, 1);
        check("t6_addr", bus.imem_addr, 0);
        wait_halt("t6_wait2");
        check("t6_cnt2", instr_count, 3);

        // Wrap: ADDR_W=2, PROG_LEN=4.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (k < 80 && !halted2) begin
            @(negedge clk);
            k++;
        end
        check("t7_halted", halted2, 1);
        check("t7_pc", pc2, 0);
        check("t7_cnt", count2, 4);
        check("t7_terr", terr2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
